// File: rtl/uart_rx_pkg.sv
// Shared definitions for the APB UART receiver.
//   - receiver FSM state encoding
//   - APB word-register indices (PADDR[3:2])
//   - USR status bit positions
//   - oversampling ratio of the bit clock
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [1:0] USR_IDX = 2'd0;
  localparam logic [1:0] URD_IDX = 2'd1;

  localparam int unsigned EMPTY = 0;
  localparam int unsigned FULL  = 1;
  localparam int unsigned OVR   = 2;
  localparam int unsigned FERR  = 3;
  localparam int unsigned PERR  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

endpackage

// File: rtl/uart_rx_apb_periph_baud.sv
// Oversample tick generator for the UART receiver.
// Emits a single-cycle tick every DIV = CLK_HZ/(BAUD*OVERSAMPLE) clocks (DIV >= 1).
// Free-runs from reset; the receiver re-aligns on each start edge, so no phase reset is needed.
// Ports:
//   PCLK    clock
//   PRESET  asynchronous active-high reset
//   tick    one-cycle pulse at OVERSAMPLE x baud rate
module baud_tick_gen
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic PCLK,
  input  logic PRESET,
  output logic tick
);

  localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_apb_periph.sv
// APB3 UART receiver: 8N1 deframer with 16x oversampling feeding a small RX FIFO.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN.
// Ports:
//   PCLK, PRESET          clock, asynchronous active-high reset
//   PADDR[3:0]            byte address, [3:2] selects USR (0) / URD (1)
//   PWDATA, PWRITE        write data, write strobe (USR bits 2..4 are W1C)
//   PSEL, PENABLE         APB select and access phase
//   PRDATA, PREADY        registered read data, registered one-wait-state ready
//   rx                    asynchronous serial input, idle high
//   rx_irq                FIFO not empty or any sticky error set
module uart_rx_apb_periph
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned BAUD    = 9600,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  // Serial input synchroniser plus one history flop for start-edge detection
  logic rx_meta_q, rx_s_q, rx_prev_q;
  logic tick;

  state_e      state_q, state_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_req, ferr_set;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q, wptr_inc, rptr_inc;
  logic               full_q, empty_q;
  logic               push, pop, ovr_set;

  logic ovr_q, ferr_q, perr;

  logic        pready_q;
  logic [31:0] prdata_q, rdata;
  logic        access, rd_urd, wr_usr;
  logic        unused_bits;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, perr_set, perr_q;
`endif

  baud_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_baud (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .tick   (tick)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        // Falling edge rather than low level: a break must return high before re-arming
        if (rx_prev_q && !rx_s_q) begin
          state_d = StStart;
          tcnt_d  = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = StData;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;  // wraps 15 -> 0 at each bit boundary
          if (tcnt_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            par_bad_d = ^{shift_q, rx_s_q};
            state_d   = StStop;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    push_req = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
    if (state_q == StParity && tick && tcnt_q == 4'd15) begin
      perr_set = ^{shift_q, rx_s_q};
    end
`endif
    if (state_q == StStop && tick && tcnt_q == 4'd15) begin
      if (!rx_s_q) begin
        ferr_set = 1'b1;
      end else begin
`ifdef UART_RX_PARITY_EN
        push_req = !par_bad_q;
`else
        push_req = 1'b1;
`endif
      end
    end
  end

  // ---------------------------------------------------------------- APB decode
  assign access = PSEL & PENABLE & ~pready_q;
  assign rd_urd = access & ~PWRITE & (PADDR[3:2] == URD_IDX);
  assign wr_usr = access &  PWRITE & (PADDR[3:2] == USR_IDX);

  // ---------------------------------------------------------------- FIFO
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign pop      = rd_urd & ~empty_q;
  assign push     = push_req & (~full_q | pop);
  assign ovr_set  = push_req & full_q & ~pop;
  assign wptr_inc = wptr_q + FIFO_AW'(1);
  assign rptr_inc = rptr_q + FIFO_AW'(1);

  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wptr_q] <= shift_q;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_inc;
      if (pop)  rptr_q <= rptr_inc;
      if (push && !pop) begin
        empty_q <= 1'b0;
        full_q  <= (wptr_inc == rptr_q);
      end else if (pop && !push) begin
        full_q  <= 1'b0;
        empty_q <= (rptr_inc == wptr_q);
      end
    end
  end

  // ---------------------------------------------------------------- sticky status
  // Set wins over a simultaneous W1C
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~(wr_usr & PWDATA[OVR]));
      ferr_q <= ferr_set | (ferr_q & ~(wr_usr & PWDATA[FERR]));
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_set | (perr_q & ~(wr_usr & PWDATA[PERR]));
    end
  end
  assign perr        = perr_q;
  assign unused_bits = ^{PWDATA[31:5], PWDATA[1:0], PADDR[1:0]};
`else
  assign perr        = 1'b0;
  assign unused_bits = ^{PWDATA[31:4], PWDATA[1:0], PADDR[1:0]};
`endif

  // ---------------------------------------------------------------- read mux and APB response
  always_comb begin
    rdata = '0;
    unique case (PADDR[3:2])
      USR_IDX: begin
        rdata[EMPTY] = empty_q;
        rdata[FULL]  = full_q;
        rdata[OVR]   = ovr_q;
        rdata[FERR]  = ferr_q;
        rdata[PERR]  = perr;
      end
      URD_IDX: rdata = empty_q ? 32'd0 : {24'd0, mem[rptr_q]};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      pready_q <= access;
      if (access && !PWRITE) begin
        prdata_q <= rdata;
      end
    end
  end

  assign PREADY = pready_q;
  assign PRDATA = prdata_q;
  assign rx_irq = ~empty_q | ovr_q | ferr_q | perr;

endmodule
